// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU codes, step states,
// bus-source bit positions and the per-step control word.
package cpu_pkg;

  localparam int unsigned OpcW   = 5;
  localparam int unsigned AluOpW = 4;
  localparam int unsigned SrcW   = 10;

  localparam logic [OpcW-1:0] LD   = 5'd0;
  localparam logic [OpcW-1:0] LDI  = 5'd1;
  localparam logic [OpcW-1:0] ST   = 5'd2;
  localparam logic [OpcW-1:0] ADD  = 5'd3;
  localparam logic [OpcW-1:0] SUB  = 5'd4;
  localparam logic [OpcW-1:0] AND  = 5'd5;
  localparam logic [OpcW-1:0] OR   = 5'd6;
  localparam logic [OpcW-1:0] ADDI = 5'd12;
  localparam logic [OpcW-1:0] ANDI = 5'd13;
  localparam logic [OpcW-1:0] ORI  = 5'd14;
  localparam logic [OpcW-1:0] MUL  = 5'd15;
  localparam logic [OpcW-1:0] DIV  = 5'd16;
  localparam logic [OpcW-1:0] MFHI = 5'd23;
  localparam logic [OpcW-1:0] MFLO = 5'd24;
  localparam logic [OpcW-1:0] NOP  = 5'd25;
  localparam logic [OpcW-1:0] HALT = 5'd26;

  localparam logic [AluOpW-1:0] AluAdd = 4'd0;
  localparam logic [AluOpW-1:0] AluSub = 4'd1;
  localparam logic [AluOpW-1:0] AluAnd = 4'd2;
  localparam logic [AluOpW-1:0] AluOr  = 4'd3;
  localparam logic [AluOpW-1:0] AluMul = 4'd4;
  localparam logic [AluOpW-1:0] AluDiv = 4'd5;

  // T6a/T6b are the two extra steps used by load/store; mul/div uses T6a only.
  typedef enum logic [2:0] {
    StT0, StT1, StT2, StT3, StT4, StT5, StT6a, StT6b
  } step_e;

  localparam int unsigned SrcRa  = 0;
  localparam int unsigned SrcRb  = 1;
  localparam int unsigned SrcRc  = 2;
  localparam int unsigned SrcPc  = 3;
  localparam int unsigned SrcHi  = 4;
  localparam int unsigned SrcLo  = 5;
  localparam int unsigned SrcZhi = 6;
  localparam int unsigned SrcZlo = 7;
  localparam int unsigned SrcMdr = 8;
  localparam int unsigned SrcC   = 9;

  typedef struct packed {
    logic [SrcW-1:0]   src;
    logic              gra;
    logic              grb;
    logic              grc;
    logic              rout;
    logic              rin;
    logic              pc_in;
    logic              ir_in;
    logic              mar_in;
    logic              mdr_in;
    logic              y_in;
    logic              z_in;
    logic              hi_in;
    logic              lo_in;
    logic              inc_pc;
    logic              read;
    logic              write;
    logic              mdatain;
    logic [AluOpW-1:0] alu_op;
    logic              wait_mem;
    logic              last;
    logic              halt;
  } ctrl_t;

  function automatic logic [AluOpW-1:0] alu_for(input logic [OpcW-1:0] op);
    case (op)
      SUB:       return AluSub;
      AND, ANDI: return AluAnd;
      OR, ORI:   return AluOr;
      MUL:       return AluMul;
      DIV:       return AluDiv;
      default:   return AluAdd;
    endcase
  endfunction

  function automatic step_e step_next(input step_e s);
    return step_e'(s + 3'd1);
  endfunction

endpackage

// File: rtl/step_decoder.sv
// Combinational decode of (control step, opcode) into the control word for that step.
module step_decoder
  import cpu_pkg::*;
(
  input  step_e           state_i,
  input  logic [OpcW-1:0] opcode_i,
  output ctrl_t           ctrl_o
);

  logic is_rrr, is_imm, is_ld, is_st, is_md;
  ctrl_t c;

  always_comb begin
    is_rrr = 1'b0;
    is_imm = 1'b0;
    is_ld  = 1'b0;
    is_st  = 1'b0;
    is_md  = 1'b0;
    case (opcode_i)
      ADD, SUB, AND, OR:    is_rrr = 1'b1;
      ADDI, ANDI, ORI, LDI: is_imm = 1'b1;
      LD:                   is_ld  = 1'b1;
      ST:                   is_st  = 1'b1;
      MUL, DIV:             is_md  = 1'b1;
      default:              ;
    endcase
  end

  always_comb begin
    c = '0;
    unique case (state_i)
      StT0: begin
        c.src[SrcPc] = 1'b1;
        c.mar_in     = 1'b1;
        c.inc_pc     = 1'b1;
        c.z_in       = 1'b1;
        c.alu_op     = AluAdd;
      end
      StT1: begin
        c.src[SrcZlo] = 1'b1;
        c.pc_in       = 1'b1;
        c.read        = 1'b1;
        c.mdatain     = 1'b1;
        c.mdr_in      = 1'b1;
        c.wait_mem    = 1'b1;
      end
      StT2: begin
        c.src[SrcMdr] = 1'b1;
        c.ir_in       = 1'b1;
      end
      StT3: begin
        if (is_rrr || is_imm || is_ld || is_st || is_md) begin
          c.grb  = 1'b1;
          c.rout = 1'b1;
          c.y_in = 1'b1;
        end else if (opcode_i == MFHI || opcode_i == MFLO) begin
          c.src[SrcHi] = (opcode_i == MFHI);
          c.src[SrcLo] = (opcode_i == MFLO);
          c.gra        = 1'b1;
          c.rin        = 1'b1;
          c.last       = 1'b1;
        end else if (opcode_i == HALT) begin
          c.halt = 1'b1;
        end else begin
          c.last = 1'b1;
        end
      end
      StT4: begin
        if (is_rrr || is_md) begin
          c.grc    = 1'b1;
          c.rout   = 1'b1;
          c.z_in   = 1'b1;
          c.alu_op = alu_for(opcode_i);
        end else if (is_imm || is_ld || is_st) begin
          c.src[SrcC] = 1'b1;
          c.z_in      = 1'b1;
          c.alu_op    = alu_for(opcode_i);
        end else begin
          c.last = 1'b1;
        end
      end
      StT5: begin
        c.src[SrcZlo] = is_rrr || is_imm || is_ld || is_st || is_md;
        c.gra         = is_rrr || is_imm;
        c.rin         = is_rrr || is_imm;
        c.mar_in      = is_ld || is_st;
        c.lo_in       = is_md;
        c.last        = !(is_ld || is_st || is_md);
      end
      StT6a: begin
        if (is_ld) begin
          c.read     = 1'b1;
          c.mdatain  = 1'b1;
          c.mdr_in   = 1'b1;
          c.wait_mem = 1'b1;
        end else if (is_st) begin
          c.gra    = 1'b1;
          c.rout   = 1'b1;
          c.mdr_in = 1'b1;
        end else if (is_md) begin
          c.src[SrcZhi] = 1'b1;
          c.hi_in       = 1'b1;
          c.last        = 1'b1;
        end else begin
          c.last = 1'b1;
        end
      end
      StT6b: begin
        if (is_ld) begin
          c.src[SrcMdr] = 1'b1;
          c.gra         = 1'b1;
          c.rin         = 1'b1;
        end else if (is_st) begin
          c.write    = 1'b1;
          c.wait_mem = 1'b1;
        end
        c.last = 1'b1;
      end
      default: c.last = 1'b1;
    endcase
    // Register-file sources follow the field strobes only while the file drives the bus.
    c.src[SrcRa] = c.gra && c.rout;
    c.src[SrcRb] = c.grb && c.rout;
    c.src[SrcRc] = c.grc && c.rout;
  end

  assign ctrl_o = c;

endmodule

// File: rtl/control_sequencer.sv
// Control-step sequencer: step FSM, memory wait/timeout counter and gated control outputs
// driving the shared datapath bus.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned OPC_W   = 5,
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned MEM_TO  = 15
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [31:0]        ir,
  input  logic               mem_ready,
  input  logic               run,
  output logic [9:0]         src_oh,
  output logic               Gra,
  output logic               Grb,
  output logic               Grc,
  output logic               Rout,
  output logic               Rin,
  output logic               PCin,
  output logic               IRin,
  output logic               MARin,
  output logic               MDRin,
  output logic               Yin,
  output logic               Zin,
  output logic               HIin,
  output logic               LOin,
  output logic               IncPC,
  output logic               Read,
  output logic               Write,
  output logic               Mdatain,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               halted,
  output logic               mem_err
);

  localparam int unsigned CntW = $clog2(MEM_TO + 1);

  step_e           state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            halted_q, halted_d;
  logic            err_q, err_d;
  logic            active_q;
  logic            en;
  ctrl_t           ctrl;
  logic            unused_ir;

  assign unused_ir = ^ir[31-OPC_W:0];

  step_decoder u_step_decoder (
    .state_i (state_q),
    .opcode_i(ir[31 -: OPC_W]),
    .ctrl_o  (ctrl)
  );

  // active_q keeps the cycle right after reset release quiet; the first edge starts fetch.
  assign en = active_q && run && !halted_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    err_d    = err_q;
    if (en) begin
      if (ctrl.halt) begin
        halted_d = 1'b1;
      end else if (ctrl.wait_mem && !mem_ready) begin
        if (cnt_q == CntW'(MEM_TO - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StT0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d   = '0;
        state_d = ctrl.last ? StT0 : step_next(state_q);
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= StT0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      active_q <= 1'b1;
    end
  end

  assign src_oh  = en ? ctrl.src : '0;
  assign Gra     = en && ctrl.gra;
  assign Grb     = en && ctrl.grb;
  assign Grc     = en && ctrl.grc;
  assign Rout    = en && ctrl.rout;
  assign Rin     = en && ctrl.rin;
  assign PCin    = en && ctrl.pc_in;
  assign IRin    = en && ctrl.ir_in;
  assign MARin   = en && ctrl.mar_in;
  assign MDRin   = en && ctrl.mdr_in;
  assign Yin     = en && ctrl.y_in;
  assign Zin     = en && ctrl.z_in;
  assign HIin    = en && ctrl.hi_in;
  assign LOin    = en && ctrl.lo_in;
  assign IncPC   = en && ctrl.inc_pc;
  assign Read    = en && ctrl.read;
  assign Write   = en && ctrl.write;
  assign Mdatain = en && ctrl.mdatain;
  assign alu_op  = en ? ALUOP_W'(ctrl.alu_op) : '0;
  assign halted  = halted_q;
  assign mem_err = err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector table plus hand-written wait/timeout/halt/clear sequences and a random
// instruction stream checking the one-source-at-a-time invariant.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        mem_ready;
  logic        run;
  logic [9:0]  src_oh;
  logic        Gra, Grb, Grc, Rout, Rin, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
  logic        IncPC, Read, Write, Mdatain;
  logic [3:0]  alu_op;
  logic        halted, mem_err;
  logic [16:0] snk;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready), .run(run),
    .src_oh(src_oh), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rout(Rout), .Rin(Rin),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Write(Write),
    .Mdatain(Mdatain), .alu_op(alu_op), .halted(halted), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  assign snk = {Gra, Grb, Grc, Rout, Rin, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
                IncPC, Read, Write, Mdatain};

  localparam logic [9:0] S_RA = 10'h001, S_RB = 10'h002, S_RC = 10'h004, S_PC = 10'h008;
  localparam logic [9:0] S_HI = 10'h010, S_LO = 10'h020, S_ZHI = 10'h040, S_ZLO = 10'h080;
  localparam logic [9:0] S_MDR = 10'h100, S_C = 10'h200;

  localparam logic [16:0] K_GRA = 17'h10000, K_GRB = 17'h08000, K_GRC = 17'h04000;
  localparam logic [16:0] K_ROUT = 17'h02000, K_RIN = 17'h01000, K_PCIN = 17'h00800;
  localparam logic [16:0] K_IRIN = 17'h00400, K_MARIN = 17'h00200, K_MDRIN = 17'h00100;
  localparam logic [16:0] K_YIN = 17'h00080, K_ZIN = 17'h00040, K_HIIN = 17'h00020;
  localparam logic [16:0] K_LOIN = 17'h00010, K_INC = 17'h00008, K_READ = 17'h00004;
  localparam logic [16:0] K_WRITE = 17'h00002, K_MDAT = 17'h00001;

  localparam logic [16:0] C_T0 = K_MARIN | K_INC | K_ZIN;
  localparam logic [16:0] C_T1 = K_PCIN | K_READ | K_MDAT | K_MDRIN;
  localparam logic [16:0] C_RB = K_GRB | K_ROUT | K_YIN;
  localparam logic [16:0] C_RC = K_GRC | K_ROUT | K_ZIN;
  localparam logic [16:0] C_WB = K_GRA | K_RIN;

  localparam logic [31:0] I_LD = 32'h00880000, I_LDI = 32'h08800005, I_ST = 32'h10880000;
  localparam logic [31:0] I_ADD = 32'h18A20000, I_SUB = 32'h20A20000, I_AND = 32'h28A20000;
  localparam logic [31:0] I_ORI = 32'h70880003, I_MUL = 32'h78A20000, I_DIV = 32'h80A20000;
  localparam logic [31:0] I_MFHI = 32'hB8800000, I_MFLO = 32'hC0800000, I_NOP = 32'hC8000000;
  localparam logic [31:0] I_HALT = 32'hD0000000, I_UND = 32'hF8000000;

  typedef struct {
    logic [31:0] ir;
    logic        rdy;
    logic        run;
    logic [9:0]  src;
    logic [16:0] ctl;
    logic [3:0]  alu;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [9:0] es, input logic [16:0] ek,
                     input logic [3:0] ea, input logic [1:0] ef);
    n_cmp++;
    if (src_oh !== es || snk !== ek || alu_op !== ea || {halted, mem_err} !== ef) begin
      n_bad++;
      $display("FAIL %s: got src=%h ctl=%h alu=%0d hlt/err=%b, want src=%h ctl=%h alu=%0d hlt/err=%b",
               nm, src_oh, snk, alu_op, {halted, mem_err}, es, ek, ea, ef);
    end
  endtask

  // Inputs applied 1 time unit after the edge, outputs sampled 1 unit later.
  task automatic cyc(input string nm, input logic [31:0] i, input logic r, input logic rn,
                     input logic [9:0] es, input logic [16:0] ek, input logic [3:0] ea,
                     input logic [1:0] ef);
    ir = i; mem_ready = r; run = rn;
    #1;
    chk(nm, es, ek, ea, ef);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_seq(input string nm, input logic [31:0] i, input logic [1:0] ef);
    cyc({nm, "_t0"}, i, 1'b1, 1'b1, S_PC, C_T0, 4'd0, ef);
    cyc({nm, "_t1"}, i, 1'b1, 1'b1, S_ZLO, C_T1, 4'd0, ef);
    cyc({nm, "_t2"}, i, 1'b1, 1'b1, S_MDR, K_IRIN, 4'd0, ef);
  endtask

  function automatic void v(input logic [31:0] i, input logic r, input logic rn,
                            input logic [9:0] s, input logic [16:0] c, input logic [3:0] a);
    tbl.push_back('{ir: i, rdy: r, run: rn, src: s, ctl: c, alu: a});
  endfunction

  function automatic void vf(input logic [31:0] i);
    v(i, 1'b1, 1'b1, S_PC, C_T0, 4'd0);
    v(i, 1'b1, 1'b1, S_ZLO, C_T1, 4'd0);
    v(i, 1'b1, 1'b1, S_MDR, K_IRIN, 4'd0);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] op;
    int         ninstr;
    logic       ok;

    clear = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = I_ADD;
    repeat (2) @(posedge clock);
    #1;
    chk("reset", 10'h0, 17'h0, 4'd0, 2'b00);
    clear = 1'b1;

    v(I_ADD, 1'b1, 1'b1, 10'h0, 17'h0, 4'd0);
    vf(I_ADD);
    v(I_ADD, 1'b1, 1'b1, S_RB, C_RB, 4'd0);
    v(I_ADD, 1'b1, 1'b1, S_RC, C_RC, 4'd0);
    v(I_ADD, 1'b1, 1'b1, S_ZLO, C_WB, 4'd0);
    // SUB with T1 held two cycles by mem_ready=0
    v(I_SUB, 1'b1, 1'b1, S_PC, C_T0, 4'd0);
    v(I_SUB, 1'b0, 1'b1, S_ZLO, C_T1, 4'd0);
    v(I_SUB, 1'b0, 1'b1, S_ZLO, C_T1, 4'd0);
    v(I_SUB, 1'b1, 1'b1, S_ZLO, C_T1, 4'd0);
    v(I_SUB, 1'b1, 1'b1, S_MDR, K_IRIN, 4'd0);
    v(I_SUB, 1'b1, 1'b1, S_RB, C_RB, 4'd0);
    v(I_SUB, 1'b1, 1'b1, S_RC, C_RC, 4'd1);
    v(I_SUB, 1'b1, 1'b1, S_ZLO, C_WB, 4'd0);
    // ORI with run=0 at T0 and at T1 (mem_ready=1 there: run wins)
    v(I_ORI, 1'b1, 1'b0, 10'h0, 17'h0, 4'd0);
    v(I_ORI, 1'b1, 1'b1, S_PC, C_T0, 4'd0);
    v(I_ORI, 1'b1, 1'b0, 10'h0, 17'h0, 4'd0);
    v(I_ORI, 1'b1, 1'b1, S_ZLO, C_T1, 4'd0);
    v(I_ORI, 1'b1, 1'b1, S_MDR, K_IRIN, 4'd0);
    v(I_ORI, 1'b1, 1'b1, S_RB, C_RB, 4'd0);
    v(I_ORI, 1'b1, 1'b1, S_C, K_ZIN, 4'd3);
    v(I_ORI, 1'b1, 1'b1, S_ZLO, C_WB, 4'd0);
    vf(I_LDI);
    v(I_LDI, 1'b1, 1'b1, S_RB, C_RB, 4'd0);
    v(I_LDI, 1'b1, 1'b1, S_C, K_ZIN, 4'd0);
    v(I_LDI, 1'b1, 1'b1, S_ZLO, C_WB, 4'd0);
    vf(I_MFHI);
    v(I_MFHI, 1'b1, 1'b1, S_HI, C_WB, 4'd0);
    vf(I_NOP);
    v(I_NOP, 1'b1, 1'b1, 10'h0, 17'h0, 4'd0);
    vf(I_UND);
    v(I_UND, 1'b1, 1'b1, 10'h0, 17'h0, 4'd0);
    vf(I_MFLO);
    v(I_MFLO, 1'b1, 1'b1, S_LO, C_WB, 4'd0);
    vf(I_MUL);
    v(I_MUL, 1'b1, 1'b1, S_RB, C_RB, 4'd0);
    v(I_MUL, 1'b1, 1'b1, S_RC, C_RC, 4'd4);
    v(I_MUL, 1'b1, 1'b1, S_ZLO, K_LOIN, 4'd0);
    v(I_MUL, 1'b1, 1'b1, S_ZHI, K_HIIN, 4'd0);
    vf(I_DIV);
    v(I_DIV, 1'b1, 1'b1, S_RB, C_RB, 4'd0);
    v(I_DIV, 1'b1, 1'b1, S_RC, C_RC, 4'd5);
    v(I_DIV, 1'b1, 1'b1, S_ZLO, K_LOIN, 4'd0);
    v(I_DIV, 1'b1, 1'b1, S_ZHI, K_HIIN, 4'd0);
    vf(I_AND);
    v(I_AND, 1'b1, 1'b1, S_RB, C_RB, 4'd0);
    v(I_AND, 1'b1, 1'b1, S_RC, C_RC, 4'd2);
    v(I_AND, 1'b1, 1'b1, S_ZLO, C_WB, 4'd0);

    foreach (tbl[k])
      cyc($sformatf("vec%0d", k), tbl[k].ir, tbl[k].rdy, tbl[k].run, tbl[k].src, tbl[k].ctl,
          tbl[k].alu, 2'b00);

    // LD: memory slow for 4 cycles at T6a
    fetch_seq("ld", I_LD, 2'b00);
    cyc("ld_t3", I_LD, 1'b1, 1'b1, S_RB, C_RB, 4'd0, 2'b00);
    cyc("ld_t4", I_LD, 1'b1, 1'b1, S_C, K_ZIN, 4'd0, 2'b00);
    cyc("ld_t5", I_LD, 1'b1, 1'b1, S_ZLO, K_MARIN, 4'd0, 2'b00);
    for (int k = 0; k < 4; k++)
      cyc("ld_wait", I_LD, 1'b0, 1'b1, 10'h0, K_READ | K_MDAT | K_MDRIN, 4'd0, 2'b00);
    cyc("ld_t6a", I_LD, 1'b1, 1'b1, 10'h0, K_READ | K_MDAT | K_MDRIN, 4'd0, 2'b00);
    cyc("ld_t6b", I_LD, 1'b1, 1'b1, S_MDR, C_WB, 4'd0, 2'b00);

    // ST: memory never answers, abandoned after 15 wait cycles
    fetch_seq("st", I_ST, 2'b00);
    cyc("st_t3", I_ST, 1'b1, 1'b1, S_RB, C_RB, 4'd0, 2'b00);
    cyc("st_t4", I_ST, 1'b1, 1'b1, S_C, K_ZIN, 4'd0, 2'b00);
    cyc("st_t5", I_ST, 1'b1, 1'b1, S_ZLO, K_MARIN, 4'd0, 2'b00);
    cyc("st_t6a", I_ST, 1'b1, 1'b1, S_RA, K_GRA | K_ROUT | K_MDRIN, 4'd0, 2'b00);
    for (int k = 0; k < 15; k++)
      cyc($sformatf("st_wait%0d", k), I_ST, 1'b0, 1'b1, 10'h0, K_WRITE, 4'd0, 2'b00);

    // HALT after the timeout: fetch resumes with mem_err set
    fetch_seq("halt", I_HALT, 2'b01);
    cyc("halt_t3", I_HALT, 1'b1, 1'b1, 10'h0, 17'h0, 4'd0, 2'b01);
    for (int k = 0; k < 3; k++)
      cyc("halted", I_ADD, 1'b1, 1'b1, 10'h0, 17'h0, 4'd0, 2'b11);

    clear = 1'b0;
    #1;
    chk("halt_clear", 10'h0, 17'h0, 4'd0, 2'b00);
    @(posedge clock);
    #1;
    clear = 1'b1;
    cyc("restart_pre", I_ADD, 1'b1, 1'b1, 10'h0, 17'h0, 4'd0, 2'b00);
    fetch_seq("prog2", I_ADD, 2'b00);
    cyc("prog2_t3", I_ADD, 1'b1, 1'b1, S_RB, C_RB, 4'd0, 2'b00);
    #1;
    chk("prog2_t4", S_RC, C_RC, 4'd0, 2'b00);
    #2;
    clear = 1'b0;
    #1;
    chk("clr_mid_t4", 10'h0, 17'h0, 4'd0, 2'b00);
    @(posedge clock);
    #1;
    chk("clr_hold", 10'h0, 17'h0, 4'd0, 2'b00);
    clear = 1'b1;
    cyc("rel_pre", I_NOP, 1'b1, 1'b1, 10'h0, 17'h0, 4'd0, 2'b00);
    cyc("rel_t0", I_NOP, 1'b1, 1'b1, S_PC, C_T0, 4'd0, 2'b00);

    // Random stream; a new instruction is presented whenever PCout marks a T0 step
    ninstr = 0;
    for (int c = 0; c < 30000 && ninstr < 2500; c++) begin
      if (src_oh[3]) begin
        op = 5'($urandom_range(0, 31));
        if (op == 5'd26) op = 5'd25;
        ir = {op, 27'($urandom)};
        ninstr++;
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      run = ($urandom_range(0, 7) != 0);
      #1;
      ok = ($countones(src_oh) <= 1) && (Zin || alu_op == 4'd0) &&
           (run || (src_oh == 10'h0 && snk == 17'h0));
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL stream_cycle%0d: src=%h ctl=%h alu=%0d run=%b, want <=1 source, alu 0 unless Zin, idle when run=0",
                 c, src_oh, snk, alu_op, run);
      end
      @(posedge clock);
      #1;
    end
    n_cmp++;
    if (ninstr < 2500) begin
      n_bad++;
      $display("FAIL stream_progress: got %0d instructions, want 2500", ninstr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
